// File: rtl/rot_shifter_axi_if.sv
// AXI4-Stream bundle shared by the rotator's input and output sides.
// tuser carries the rotate amount on the input side; the output side leaves it at zero.
interface rot_shifter_axi_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 8
) ();
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;

    // Producer side: drives the payload and valid, observes ready.
    modport master (
        output tdata,
        output tuser,
        output tvalid,
        input  tready
    );

    // Consumer side: observes the payload and valid, drives ready.
    modport slave (
        input  tdata,
        input  tuser,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/rot_shifter_axi.sv
// 64-bit streaming left-rotate unit.
// Each accepted beat is rotated left by tuser[5:0] through a six-level
// logarithmic barrel. Optional elastic registers sit before and after the
// barrel; each holds its own valid flag and accepts a new beat whenever it
// is empty or is being drained in the same cycle, so a full pipeline still
// moves one beat per clock.
module rot_shifter_axi #(
    parameter int PIPELINE_INPUT  = 1,
    parameter int PIPELINE_OUTPUT = 1,
    parameter int REGISTER_RESET  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    rot_shifter_axi_if.slave  s_axis,
    rot_shifter_axi_if.master m_axis
);

    localparam int DATA_W  = 64;
    localparam int SHIFT_W = 6;
    localparam int LEVELS  = SHIFT_W;

    // Ready into the input stage (or straight through when it is bypassed).
    logic               in_ready;
    logic               s_fire;

    // Beat presented to the barrel rotator and the handshake around it.
    logic               mid_valid;
    logic               mid_ready;
    logic [DATA_W-1:0]  mid_data;
    logic [SHIFT_W-1:0] mid_shift;

    // Barrel output.
    logic [DATA_W-1:0]  rot_data;

    // Upper rotate-amount bits are ignored: amounts wrap modulo 64.
    logic               unused_tuser_hi;
    assign unused_tuser_hi = ^s_axis.tuser[7:6];

    // Nothing is accepted while reset is held, whatever the pipeline state.
    assign s_axis.tready = rst_n & in_ready;
    assign s_fire        = s_axis.tvalid & s_axis.tready;

    // The rotate amount is consumed here; no sideband leaves the block.
    assign m_axis.tuser  = '0;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    if (PIPELINE_INPUT != 0) begin : g_in_reg
        logic               in_valid_q;
        logic [DATA_W-1:0]  in_data_q;
        logic [SHIFT_W-1:0] in_shift_q;

        // Empty, or emptying this cycle, means room for the next beat.
        assign in_ready  = !in_valid_q || mid_ready;
        assign mid_valid = in_valid_q;
        assign mid_data  = in_data_q;
        assign mid_shift = in_shift_q;

        // Input valid flag: set on accept, cleared when drained with no refill.
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                in_valid_q <= 1'b0;
            end else if (s_fire) begin
                in_valid_q <= 1'b1;
            end else if (mid_ready) begin
                in_valid_q <= 1'b0;
            end
        end

        // Input payload: captured on accept, optionally cleared by reset.
        // NOTE: payload flops carry no reset unless REGISTER_RESET is set;
        // the valid flag alone decides whether their contents mean anything.
        always_ff @(posedge clk) begin
            if ((REGISTER_RESET != 0) && !rst_n) begin
                in_data_q  <= '0;
                in_shift_q <= '0;
            end else if (s_fire) begin
                in_data_q  <= s_axis.tdata;
                in_shift_q <= s_axis.tuser[SHIFT_W-1:0];
            end
        end
    end else begin : g_in_comb
        assign in_ready  = mid_ready;
        assign mid_valid = s_axis.tvalid & rst_n;
        assign mid_data  = s_axis.tdata;
        assign mid_shift = s_axis.tuser[SHIFT_W-1:0];
    end

    // ------------------------------------------------------------------
    // Barrel rotator: level k rotates by 2**k when mid_shift[k] is set
    // ------------------------------------------------------------------
    logic [LEVELS:0][DATA_W-1:0] rot_stage;

    assign rot_stage[0] = mid_data;

    for (genvar g = 0; g < LEVELS; g++) begin : g_rot
        localparam int AMT = 1 << g;
        assign rot_stage[g+1] = mid_shift[g]
            ? {rot_stage[g][DATA_W-1-AMT:0], rot_stage[g][DATA_W-1:DATA_W-AMT]}
            : rot_stage[g];
    end

    assign rot_data = rot_stage[LEVELS];

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    if (PIPELINE_OUTPUT != 0) begin : g_out_reg
        logic              out_valid_q;
        logic [DATA_W-1:0] out_data_q;
        logic              mid_fire;

        assign mid_ready     = !out_valid_q || m_axis.tready;
        assign mid_fire      = mid_valid & mid_ready;
        assign m_axis.tvalid = out_valid_q;
        assign m_axis.tdata  = out_data_q;

        // Output valid flag: set on load, cleared when drained with no refill.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                out_valid_q <= 1'b0;
            end else if (mid_fire) begin
                out_valid_q <= 1'b1;
            end else if (m_axis.tready) begin
                out_valid_q <= 1'b0;
            end
        end

        // Output payload: holds the rotated word until the consumer takes it.
        always_ff @(posedge clk) begin
            if ((REGISTER_RESET != 0) && !rst_n) begin
                out_data_q <= '0;
            end else if (mid_fire) begin
                out_data_q <= rot_data;
            end
        end

        // A stalled output beat must not change or disappear.
        property p_hold_under_stall;
            @(posedge clk) disable iff (!rst_n)
                (m_axis.tvalid && !m_axis.tready) |=>
                    (m_axis.tvalid && $stable(m_axis.tdata));
        endproperty
        a_hold_under_stall : assert property (p_hold_under_stall);
    end else begin : g_out_comb
        assign mid_ready     = m_axis.tready;
        assign m_axis.tvalid = mid_valid;
        assign m_axis.tdata  = rot_data;
    end

endmodule

// File: tb/tb_rot_shifter_axi.sv
// Directed and streamed checks for rot_shifter_axi in its default
// two-register configuration: reset state, hand-computed rotations,
// wrap of large rotate amounts, sustained throughput, backpressure and
// reset with beats in flight.
module tb_rot_shifter_axi;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rot_shifter_axi_if s_if ();
    rot_shifter_axi_if m_if ();

    rot_shifter_axi #(
        .PIPELINE_INPUT (1),
        .PIPELINE_OUTPUT(1),
        .REGISTER_RESET (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axis(s_if),
        .m_axis(m_if)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] D_A = 64'h08000000A0000001;
    localparam logic [63:0] D_B = 64'h0123456789ABCDEF;

    int n_tests   = 0;
    int n_fail    = 0;
    int out_count = 0;
    logic [63:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference rotate written as shift-and-or on the full amount modulo 64.
    function automatic logic [63:0] rot64(input logic [63:0] d, input logic [7:0] s);
        int unsigned a;
        a = int'(s % 8'd64);
        if (a == 0) return d;
        return (d << a) | (d >> (64 - a));
    endfunction

    // Scoreboard: record accepted beats, compare every emitted beat in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (s_if.tvalid && s_if.tready)
                exp_q.push_back(rot64(s_if.tdata, s_if.tuser));
            if (m_if.tvalid && m_if.tready) begin
                out_count++;
                if (exp_q.size() == 0)
                    check("spurious_beat", {63'd0, m_if.tvalid}, 64'd0);
                else
                    check("stream_data", m_if.tdata, exp_q.pop_front());
            end
        end
    end

    // Present one beat and hold it until accepted; returns just after the accept edge.
    task automatic send(input logic [63:0] d, input logic [7:0] u);
        int waited = 0;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        while (!s_if.tready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited == 20) check("accept_timeout", {63'd0, s_if.tready}, 64'd1);
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    // Single beat through an empty pipeline: check fill latency and result.
    task automatic run_vec(input string tag, input logic [63:0] d, input logic [7:0] u,
                           input logic [63:0] exp);
        int lat = 0;
        send(d, u);
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (m_if.tvalid) break;
        end
        check({tag, "_latency"}, 64'(lat), 64'd2);
        check({tag, "_data"}, m_if.tdata, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int start;

        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", {63'd0, s_if.tready}, 64'd0);
        check("rst_m_tvalid", {63'd0, m_if.tvalid}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_tready", {63'd0, s_if.tready}, 64'd1);
        check("post_rst_m_tvalid", {63'd0, m_if.tvalid}, 64'd0);
        @(posedge clk);
        #1;

        // Directed rotations with hand-computed results.
        run_vec("rot0",     D_A, 8'd0,   D_A);
        run_vec("rot3",     D_A, 8'd3,   64'h4000000500000008);
        run_vec("rot10",    D_A, 8'd10,  64'h0000028000000420);
        run_vec("rot63",    D_A, 8'd63,  64'h8400000050000000);
        run_vec("rot_0x43", D_A, 8'h43,  64'h4000000500000008);
        run_vec("rot64",    D_A, 8'h40,  D_A);
        run_vec("rot255",   D_B, 8'hFF,  64'h8091A2B3C4D5E6F7);
        run_vec("rot32",    D_B, 8'd32,  64'h89ABCDEF01234567);
        run_vec("rot1_msb", 64'h8000000000000000, 8'd1, 64'h0000000000000001);

        // Back-to-back random stream with the consumer always ready.
        m_if.tready = 1'b1;
        start = out_count;
        for (int i = 0; i < 20; i++) begin
            send({$urandom, $urandom}, 8'($urandom_range(0, 255)));
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        check("stream_count", 64'(out_count - start), 64'd20);

        // Backpressure: two beats fill the pipeline, a third waits, output holds.
        start = out_count;
        m_if.tready = 1'b0;
        send(D_A, 8'd3);
        send(D_A, 8'd10);
        s_if.tdata  = D_A;
        s_if.tuser  = 8'd63;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_s_tready", {63'd0, s_if.tready}, 64'd0);
            check("bp_m_tvalid", {63'd0, m_if.tvalid}, 64'd1);
            check("bp_m_tdata",  m_if.tdata, 64'h4000000500000008);
        end
        @(posedge clk);
        #1 m_if.tready = 1'b1;
        send(D_A, 8'd63);
        send(D_A, 8'd0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        check("bp_count", 64'(out_count - start), 64'd4);

        // One-cycle reset with two beats in flight.
        m_if.tready = 1'b0;
        send(D_A, 8'd3);
        send(D_A, 8'd10);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_s_tready", {63'd0, s_if.tready}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_m_tvalid", {63'd0, m_if.tvalid}, 64'd0);
        check("midrst_s_tready_after", {63'd0, s_if.tready}, 64'd1);
        @(posedge clk);
        #1 m_if.tready = 1'b1;
        start = out_count;
        run_vec("post_midrst_rot10", D_A, 8'd10, 64'h0000028000000420);
        repeat (5) @(posedge clk);
        #1;
        check("post_midrst_count", 64'(out_count - start), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
